// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline latch, WB-to-MEM store-data forwarding and a word-organised data memory.
// Loads read asynchronously from the latched address; stores commit on the edge that ends MEM.
module ex_mem_stage #(
  parameter int DM_WORDS  = 4096,
  parameter int DM_ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] instructure_in,
  input  logic [5:0]  instr_code_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] reg_read_data2_in,
  input  logic        forward_store_src,
  input  logic [31:0] forward_data_WB,
  output logic [31:0] pc_out,
  output logic [31:0] instructure_out,
  output logic [5:0]  instr_code_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_read_data_out,
  output logic [31:0] forward_data_MEM
);

  localparam logic [5:0] C_NOP = 6'd0;
  localparam logic [5:0] C_LB  = 6'd1;
  localparam logic [5:0] C_LH  = 6'd2;
  localparam logic [5:0] C_LW  = 6'd3;
  localparam logic [5:0] C_LBU = 6'd4;
  localparam logic [5:0] C_LHU = 6'd5;
  localparam logic [5:0] C_SB  = 6'd6;
  localparam logic [5:0] C_SH  = 6'd7;
  localparam logic [5:0] C_SW  = 6'd8;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [5:0]  code_q, code_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] rt_q, rt_d;

  logic [31:0]          mem_q [DM_WORDS];
  logic [DM_ADDR_W-1:0] word_idx;
  logic [31:0]          rd_word;
  logic [31:0]          sd;
  logic [15:0]          rd_half;
  logic [7:0]           rd_byte;
  logic                 wr_en;
  logic [31:0]          wr_word;

  // Flush beats stall: the bubble replaces whatever was held.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    code_d  = code_q;
    alu_d   = alu_q;
    rt_d    = rt_q;
    if (flush) begin
      pc_d    = '0;
      instr_d = '0;
      code_d  = C_NOP;
      alu_d   = '0;
      rt_d    = '0;
    end else if (!stall) begin
      pc_d    = pc_in;
      instr_d = instructure_in;
      code_d  = instr_code_in;
      alu_d   = alu_result_in;
      rt_d    = reg_read_data2_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      instr_q <= '0;
      code_q  <= C_NOP;
      alu_q   <= '0;
      rt_q    <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      code_q  <= code_d;
      alu_q   <= alu_d;
      rt_q    <= rt_d;
    end
  end

  assign word_idx = alu_q[DM_ADDR_W+1:2];
  assign rd_word  = mem_q[word_idx];
  assign sd       = forward_store_src ? forward_data_WB : rt_q;
  assign rd_half  = alu_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    rd_byte = rd_word[7:0];
    case (alu_q[1:0])
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      2'd3:    rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
  end

  // Sub-word stores merge into the current word; the stalled instruction never writes.
  always_comb begin
    wr_en   = 1'b0;
    wr_word = rd_word;
    if (!stall) begin
      case (code_q)
        C_SW: begin
          wr_en   = 1'b1;
          wr_word = sd;
        end
        C_SH: begin
          wr_en = 1'b1;
          if (alu_q[1]) wr_word[31:16] = sd[15:0];
          else          wr_word[15:0]  = sd[15:0];
        end
        C_SB: begin
          wr_en = 1'b1;
          case (alu_q[1:0])
            2'd1:    wr_word[15:8]  = sd[7:0];
            2'd2:    wr_word[23:16] = sd[7:0];
            2'd3:    wr_word[31:24] = sd[7:0];
            default: wr_word[7:0]   = sd[7:0];
          endcase
        end
        default: wr_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[word_idx] <= wr_word;
`ifndef SYNTHESIS
      $display("store pc=%h addr=%h data=%h", pc_q, {alu_q[31:2], 2'b00}, wr_word);
`endif
    end
  end

  always_comb begin
    mem_read_data_out = '0;
    case (code_q)
      C_LW:    mem_read_data_out = rd_word;
      C_LH:    mem_read_data_out = {{16{rd_half[15]}}, rd_half};
      C_LHU:   mem_read_data_out = {16'h0000, rd_half};
      C_LB:    mem_read_data_out = {{24{rd_byte[7]}}, rd_byte};
      C_LBU:   mem_read_data_out = {24'h000000, rd_byte};
      default: mem_read_data_out = '0;
    endcase
  end

  assign pc_out           = pc_q;
  assign instructure_out  = instr_q;
  assign instr_code_out   = code_q;
  assign alu_result_out   = alu_q;
  assign forward_data_MEM = alu_q;

endmodule
